fifo_status: RTL and testbench
==============================

FIFO_STATUS -- requirements
Module: fifo_status

Interface
REQ-001 SHALL have parameter B, default 8, data word width in bits.
REQ-002 SHALL have parameter W, default 4, address bits; depth is 2**W words.
REQ-003 SHALL have parameter AF_LEVEL, default 2**W-2, almost-full threshold in words (1..2**W).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in words (0..2**W-1).
REQ-005 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr  input  1  write request, sampled on rising clk.
REQ-008 SHALL have port rd  input  1  read/pop request, sampled on rising clk.
REQ-009 SHALL have port w_data  input  B  write data.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port r_data  output  B  head-of-queue word (show-ahead).
REQ-012 SHALL have port empty  output  1  no words stored.
REQ-013 SHALL have port full  output  1  2**W words stored.
REQ-014 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-015 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-016 SHALL have port count  output  W+1  words stored, 0..2**W.
REQ-017 SHALL have ports overflow, underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-018 SHALL accept a write when wr=1 and full=0, or wr=1 and rd=1 and full=1; other writes are dropped with no state change.
REQ-019 SHALL accept a read when rd=1 and empty=0; a read when empty=1 is ignored, even if wr=1 in the same cycle.
REQ-020 SHALL present r_data combinationally from the storage word at the read pointer; r_data is undefined while empty=1.
REQ-021 SHALL make a written word visible on r_data, with empty deasserted, in the cycle after the accepting edge when the FIFO was empty.
REQ-022 SHALL advance the write and read pointers modulo 2**W, wrapping from 2**W-1 to 0.
REQ-023 SHALL update count by +1 for a write only, -1 for a read only, and 0 for both or neither accepted.
REQ-024 SHALL register empty, full, almost_empty and almost_full from the next-state count, so all flags change on the same edge as count.
REQ-025 SHALL, with wr=rd=1 and full=1, pop the head word and write w_data into the freed slot in the same cycle; full stays 1.
REQ-026 SHALL, with wr=rd=1 and 0<count<2**W, accept both; count and all flags are unchanged.

Reset
REQ-027 SHALL on reset=1, asynchronously, set both pointers to 0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0 and underflow=0.
REQ-028 SHALL leave storage contents uninitialised on reset, and SHALL discard any transfer in progress when reset asserts mid-operation.

Configuration
REQ-029 SHALL, when macro FIFO_STATUS_ERR_FLAGS_EN is defined, set overflow on any edge with a dropped write, and set underflow on any edge with an ignored read.
REQ-030 SHALL hold overflow and underflow set until clr_err=1 at a clock edge; when a set condition coincides with clr_err=1, the flag ends the cycle set.
REQ-031 SHALL, when FIFO_STATUS_ERR_FLAGS_EN is undefined, tie overflow and underflow to 0, ignore clr_err, and instantiate no flag registers.

Verification
REQ-032 Test 1: B=8, W=4; reset, then write 0x01..0x10 on 16 edges -> full=1, count=16, almost_full=1 from count 14; r_data=0x01.
REQ-033 Test 2: from full, wr=1 with 0xAA, rd=0 -> count stays 16, data is lost, overflow=1 (macro on) or 0 (macro off).
REQ-034 Test 3: from full, wr=rd=1 with 0xBB -> r_data=0x02, count=16; then 16 reads return 0x02..0x10 followed by 0xBB, and empty=1.
REQ-035 Test 4: from empty, wr=rd=1 with 0x55 -> count=1, empty=0, r_data=0x55 next cycle, underflow=1 (macro on); then clr_err=1 -> underflow=0.
REQ-036 Test 5: perform 40 interleaved single writes and reads crossing pointer wrap -> read data order matches write order, and count never exceeds 1.
REQ-037 Test 6: assert reset mid-burst at count=7 -> count=0, empty=1, almost_empty=1 immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_status.sv
`default_nettype none
// ============================================================================
// Module   : fifo_status
// Purpose  : Synchronous show-ahead FIFO with registered status flags
//            (empty, full, almost_empty, almost_full), an occupancy count and
//            optional sticky overflow/underflow error flags.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   B        data word width in bits
//   W        address bits; depth is 2**W words
//   AF_LEVEL almost-full threshold in words (1..2**W)
//   AE_LEVEL almost-empty threshold in words (0..2**W-1)
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   wr           in   write request
//   rd           in   read/pop request
//   w_data       in   [B-1:0] write data
//   clr_err      in   synchronous clear of the sticky error flags
//   r_data       out  [B-1:0] head-of-queue word (show-ahead)
//   empty        out  no words stored
//   full         out  2**W words stored
//   almost_empty out  count <= AE_LEVEL
//   almost_full  out  count >= AF_LEVEL
//   count        out  [W:0] words stored
//   overflow     out  sticky: a write was dropped
//   underflow    out  sticky: a read was ignored
// Configuration
//   FIFO_STATUS_ERR_FLAGS_EN  when defined, builds the sticky error flags;
//                             otherwise overflow/underflow are tied to 0 and
//                             clr_err is ignored.
// ============================================================================
module fifo_status #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int         DEPTH     = 2**W;
  localparam logic [W:0] DEPTH_CNT = (W+1)'(DEPTH);
  localparam logic [W:0] AF_CNT    = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_CNT    = (W+1)'(AE_LEVEL);

  logic [B-1:0] mem [0:DEPTH-1];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W:0]   count_next;
  logic         do_wr;
  logic         do_rd;

  // A read is only honoured when data is present. A write into a full FIFO
  // is legal only when the same edge frees a slot through an accepted read.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_next = count - 1'b1;
    end
  end

  // Storage carries no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= w_data;
    end
  end

  assign r_data = mem[rd_ptr];

  // Pointers wrap naturally at 2**W because they are exactly W bits wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Flags are decoded from the next-state count so they move on the same
  // edge as count itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_CNT);
      almost_empty <= (count_next <= AE_CNT);
      almost_full  <= (count_next >= AF_CNT);
    end
  end

`ifdef FIFO_STATUS_ERR_FLAGS_EN
  logic ovf_set;
  logic udf_set;

  assign ovf_set = wr & ~do_wr;
  assign udf_set = rd & ~do_rd;

  // A new error on the same edge as clr_err wins, so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_status.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_status
// Purpose  : Self-checking bench for fifo_status (B=8, W=4). A queue holds
//            the words the FIFO should contain; reads pop it and compare with
//            r_data, and status outputs are compared with values derived from
//            the queue depth after every edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_status;

  localparam int B     = 8;
  localparam int W     = 4;
  localparam int DEPTH = 16;

  logic         clk;
  logic         reset;
  logic         wr;
  logic         rd;
  logic [B-1:0] w_data;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  fifo_status #(
    .B        (B),
    .W        (W),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .w_data       (w_data),
    .clr_err      (clr_err),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_pass  = 0;
  logic [B-1:0] sb [$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    check({tag, "_count"}, 32'(count), 32'(n));
    check({tag, "_empty"}, 32'(empty), 32'(n == 0));
    check({tag, "_full"},  32'(full),  32'(n == DEPTH));
    check({tag, "_ae"},    32'(almost_empty), 32'(n <= 2));
    check({tag, "_af"},    32'(almost_full),  32'(n >= 14));
    check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, "_udf"},   32'(underflow), 32'(m_udf));
  endtask

  // One clock cycle of stimulus. Called at posedge+1 so r_data is settled.
  task automatic cycle(input string tag, input logic w, input logic r,
                       input logic [B-1:0] d, input logic c);
    logic         m_full;
    logic         m_empty;
    logic         acc_rd;
    logic         acc_wr;
    logic [B-1:0] exp_d;
    m_full  = (sb.size() == DEPTH);
    m_empty = (sb.size() == 0);
    acc_rd  = r && !m_empty;
    acc_wr  = w && (!m_full || acc_rd);
    wr      = w;
    rd      = r;
    w_data  = d;
    clr_err = c;
    if (acc_rd) begin
      exp_d = sb.pop_front();
      check({tag, "_rdata"}, 32'(r_data), 32'(exp_d));
    end
    if (acc_wr) begin
      sb.push_back(d);
    end
`ifdef FIFO_STATUS_ERR_FLAGS_EN
    if (w && !acc_wr) m_ovf = 1'b1;
    else if (c)       m_ovf = 1'b0;
    if (r && !acc_rd) m_udf = 1'b1;
    else if (c)       m_udf = 1'b0;
`endif
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    rd      = 1'b0;
    w_data  = '0;
    clr_err = 1'b0;
    #12;
    check_state("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_reset");

    // Test 1: fill to 16 words
    for (int i = 1; i <= DEPTH; i++) begin
      cycle("t1_fill", 1'b1, 1'b0, 8'(i), 1'b0);
    end
    check("t1_head", 32'(r_data), 32'h01);

    // Test 2: write while full is dropped
    cycle("t2_drop", 1'b1, 1'b0, 8'hAA, 1'b0);
    check("t2_head", 32'(r_data), 32'h01);

    // Test 3: simultaneous read/write while full, then drain
    cycle("t3_rw_full", 1'b1, 1'b1, 8'hBB, 1'b0);
    check("t3_head", 32'(r_data), 32'h02);
    for (int i = 0; i < DEPTH; i++) begin
      cycle("t3_drain", 1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("t3_empty", 32'(empty), 32'h1);

    // Test 4: simultaneous read/write while empty: write only
    cycle("t4_rw_empty", 1'b1, 1'b1, 8'h55, 1'b0);
    check("t4_rdata", 32'(r_data), 32'h55);
    cycle("t4_clr", 1'b0, 1'b0, 8'h00, 1'b1);
    cycle("t4_pop", 1'b0, 1'b1, 8'h00, 1'b0);
    // error on the same edge as clear: flag stays set
    cycle("t4_set_clr", 1'b0, 1'b1, 8'h00, 1'b1);
    cycle("t4_clr2", 1'b0, 1'b0, 8'h00, 1'b1);

    // Test 5: interleaved single writes and reads across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle("t5_wr", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      check("t5_cnt_le1", 32'(count <= 1), 32'h1);
      cycle("t5_rd", 1'b0, 1'b1, 8'h00, 1'b0);
      check("t5_cnt_le1", 32'(count <= 1), 32'h1);
    end

    // Test 6: asynchronous reset in the middle of a burst at count 7
    for (int i = 0; i < 7; i++) begin
      cycle("t6_fill", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    end
    wr     = 1'b1;
    w_data = 8'hEE;
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state("t6_async");
    wr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_state("t6_held");
    cycle("t6_after_wr", 1'b1, 1'b0, 8'h77, 1'b0);
    cycle("t6_after_rd", 1'b0, 1'b1, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
